apb_irq_ctrl: RTL
=================

Name: apb_irq_ctrl

Overview:
- APB3 slave interrupt controller that sits downstream of the timer peripheral and consumes its timer_irq vector (overflow and compare per timer).
- Latches per-source events into pending bits and applies an enable mask.
- Produces one level interrupt to the core plus the ID of the highest-priority source.
- Software uses a claim register to service sources one at a time.

Parameters:
- NumIrq, 8, number of interrupt sources (1..32); typically TimerCount*2.
- APB_ADDR_WIDTH, 12, PADDR width; only PADDR[4:2] is decoded.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- PSEL  in  1  APB select.
- PENABLE  in  1  APB access phase.
- PWRITE  in  1  1 = write.
- PADDR  in  APB_ADDR_WIDTH  byte address.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  always 1.
- PSLVERR  out  1  error for an unmapped or illegal access.
- irq_i  in  NumIrq  interrupt sources, synchronous to clk_i.
- irq_o  out  1  core interrupt.
- irq_id_o  out  5  index of the highest-priority pending and enabled source; 0 when none.

Behaviour:
- Reset (rst_i high at a clock edge):
  - pending=0, enable=0, edge_sel=all ones, irq_q=0.
  - irq_o=0, irq_id_o=0.
  - Any claim side effect in that cycle is discarded.
- Register map (PADDR[4:2]); bits at or above NumIrq read 0 and ignore writes:
  - 0x00 PENDING: RO.
  - 0x04 ENABLE: RW.
  - 0x08 CLEAR: WO, write-1-to-clear pending; reads 0.
  - 0x0C SET: WO, write-1-to-set pending as a software trigger; reads 0.
  - 0x10 CLAIM: RO with side effect.
  - 0x14 EDGE_SEL: RW; 1 = rising-edge mode, 0 = level mode.
  - 0x18 and 0x1C: unmapped.
- APB protocol:
  - Transfer occurs when PSEL&PENABLE. Zero wait states.
  - PRDATA is combinational from current state during the access; it is 0 outside an access.
  - PSLVERR=1 during an access to an unmapped address, or a write to PENDING or CLAIM. Such accesses have no side effect.
- Event capture, per source i, evaluated every edge:
  - irq_q <= irq_i.
  - Edge mode: set_i = irq_i & ~irq_q.
  - Level mode: set_i = irq_i.
  - After reset, a source held high produces a set on the first cycle.
- Pending next state:
  - pending_next = (pending & ~clr) | set_hw | set_sw.
  - clr comes from a CLEAR write or a claim. Hardware or software set wins over a clear in the same cycle, so no events are lost.
  - A level-mode source still high after a clear re-pends on the next edge.
- Outputs:
  - active = pending & enable.
  - irq_o = |active, registered: it reflects the active value one cycle after pending or enable changes.
  - irq_id_o is registered the same way. Priority is fixed: lowest index wins.
  - Total latency from an irq_i rising edge (sampled at edge n) to irq_o high is 2 edges: pending at n, irq_o at n+1.
- CLAIM read:
  - PRDATA = {27'b0, id+1} of the highest-priority active source, or 0 if none.
  - At the end of that access the claimed pending bit is cleared (a concurrent set still wins).
  - Disabled sources are never claimed.
- Clearing ENABLE masks a source but does not clear its pending bit; re-enabling re-raises irq_o.

Test Plan:
- Reset values: assert rst_i 2 cycles -> all register reads return 0 except EDGE_SEL=0xFF (NumIrq=8); irq_o=0; PSLVERR=0 on reads of 0x00–0x14.
- Edge capture: write ENABLE=0x05, pulse irq_i[2] for 1 cycle -> PENDING=0x04, irq_o high 2 edges after the pulse, irq_id_o=2; a 10-cycle-high pulse sets the bit only once.
- Priority and claim: with sources 2 and 0 both pending and ENABLE=0x05 -> first CLAIM returns 1 and PENDING becomes 0x04; second CLAIM returns 3, irq_o drops 1 cycle later; third CLAIM returns 0.
- Level mode: write EDGE_SEL=0xFE, hold irq_i[0]=1, write CLEAR=0x01 -> PENDING bit 0 is 1 again on the next read; release irq_i[0], CLEAR -> stays 0.
- Set/clear collision: irq_i[1] rising in the same cycle as a CLEAR=0x02 write -> PENDING[1]=1 afterwards; SET=0x80 with ENABLE=0 -> irq_o stays 0, then ENABLE=0x80 -> irq_o=1, irq_id_o=7.
- Errors and reset mid-operation: read 0x18 -> PSLVERR=1, PRDATA=0; write 0x10 -> PSLVERR=1, PENDING unchanged; rst_i asserted during a CLAIM access with pending=0x03 -> after reset PENDING=0, ENABLE=0, irq_o=0.

Source files
------------

// File: rtl/apb_irq_ctrl.sv
// APB3 interrupt controller: per-source edge/level capture into pending bits,
// enable mask, fixed lowest-index priority and a claim register.
module apb_irq_cell (
  input  logic clk_i,
  input  logic rst_i,
  input  logic src,
  input  logic edge_mode,
  input  logic clr,
  input  logic set_sw,
  output logic pending
);
  logic src_q;
  logic set_hw;

  // In edge mode only a 0->1 transition sets; a set always beats a clear.
  assign set_hw = src & ~(edge_mode & src_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      src_q   <= 1'b0;
      pending <= 1'b0;
    end else begin
      src_q   <= src;
      pending <= (pending & ~clr) | set_hw | set_sw;
    end
  end
endmodule

module apb_irq_ctrl #(
  parameter int NumIrq         = 8,
  parameter int APB_ADDR_WIDTH = 12
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  input  logic [NumIrq-1:0]         irq_i,
  output logic                      irq_o,
  output logic [4:0]                irq_id_o
);
  localparam logic [2:0] A_PEND = 3'd0, A_EN = 3'd1, A_CLR = 3'd2,
                         A_SET  = 3'd3, A_CLM = 3'd4, A_EDG = 3'd5;

  logic [NumIrq-1:0] pending, enable, edge_sel, active;
  logic [NumIrq-1:0] clr, set_sw, claim_mask, wd;
  logic [2:0]        idx;
  logic              access, err, wr, rd, any_act, claim;
  logic [4:0]        id_c;
  logic              unused_bits;

  assign unused_bits = ^{PADDR, PWDATA};

  assign idx     = PADDR[4:2];
  assign wd      = PWDATA[NumIrq-1:0];
  assign access  = PSEL & PENABLE;
  assign err     = (idx > A_EDG) | (PWRITE & ((idx == A_PEND) | (idx == A_CLM)));
  assign PSLVERR = access & err;
  assign PREADY  = 1'b1;
  assign wr      = access & ~err & PWRITE;
  assign rd      = access & ~err & ~PWRITE;
  assign active  = pending & enable;

  always_comb begin
    id_c    = '0;
    any_act = 1'b0;
    for (int i = NumIrq - 1; i >= 0; i--) begin
      if (active[i]) begin
        id_c    = 5'(i);
        any_act = 1'b1;
      end
    end
  end

  assign claim = rd & (idx == A_CLM) & any_act;

  always_comb begin
    claim_mask = '0;
    if (claim) claim_mask[id_c] = 1'b1;
  end

  assign clr    = ((wr && idx == A_CLR) ? wd : '0) | claim_mask;
  assign set_sw = (wr && idx == A_SET) ? wd : '0;

  generate
    for (genvar g = 0; g < NumIrq; g++) begin : g_cell
      apb_irq_cell u_cell (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .src       (irq_i[g]),
        .edge_mode (edge_sel[g]),
        .clr       (clr[g]),
        .set_sw    (set_sw[g]),
        .pending   (pending[g])
      );
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enable   <= '0;
      edge_sel <= '1;
      irq_o    <= 1'b0;
      irq_id_o <= '0;
    end else begin
      if (wr && idx == A_EN)  enable   <= wd;
      if (wr && idx == A_EDG) edge_sel <= wd;
      irq_o    <= any_act;
      irq_id_o <= id_c;
    end
  end

  always_comb begin
    PRDATA = '0;
    if (rd) begin
      case (idx)
        A_PEND:  PRDATA = 32'(pending);
        A_EN:    PRDATA = 32'(enable);
        A_CLM:   PRDATA = any_act ? 32'(id_c) + 32'd1 : 32'd0;
        A_EDG:   PRDATA = 32'(edge_sel);
        default: PRDATA = '0;
      endcase
    end
  end
endmodule
